// File: rtl/mmio_timer_gpio_if.sv
// rtl/mmio_timer_gpio_if.sv - CPU data-bus load/store port seen by the timer/GPIO peripheral
interface mmio_timer_gpio_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        hit;

    modport master (
        output addr,
        output write_data,
        output funct3,
        output mem_read,
        output mem_write,
        input  read_data,
        input  hit
    );

    modport slave (
        input  addr,
        input  write_data,
        input  funct3,
        input  mem_read,
        input  mem_write,
        output read_data,
        output hit
    );
endinterface

// File: rtl/mmio_timer_gpio.sv
// rtl/mmio_timer_gpio.sv - memory-mapped GPIO out/in registers and prescaled compare timer
// Loads answer combinationally in the same cycle; stores commit on the rising clk edge.
module mmio_timer_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          PRESCALE  = 4,
    parameter int          GPIO_IN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_timer_gpio_if.slave     bus,
    output logic [31:0]          gpio_out,
    input  logic [GPIO_IN_W-1:0] gpio_in,
    output logic                 irq
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    localparam logic [5:0] IDX_GPIO_OUT = 6'h00;
    localparam logic [5:0] IDX_GPIO_IN  = 6'h01;
    localparam logic [5:0] IDX_CTRL     = 6'h02;
    localparam logic [5:0] IDX_COUNT    = 6'h03;
    localparam logic [5:0] IDX_CMP      = 6'h04;
    localparam logic [5:0] IDX_STATUS   = 6'h05;

    logic [2:0]           ctrl;
    logic [31:0]          count;
    logic [31:0]          cmp;
    logic                 pending;
    logic [15:0]          presc;
    logic [GPIO_IN_W-1:0] sync1;
    logic [GPIO_IN_W-1:0] sync2;

    logic        sel_hit;
    logic [5:0]  word_idx;
    logic [1:0]  lane;
    logic        load_ok;
    logic        store_ok;
    logic [3:0]  byte_mask;
    logic [31:0] bit_mask;
    logic [31:0] store_data;
    logic [31:0] reg_word;
    logic [31:0] byte_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    logic        wr_en;
    logic        wr_gpio;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic [2:0]  ctrl_new;
    logic        status_clear;
    logic        tick;
    logic        match;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    assign sel_hit  = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign word_idx = bus.addr[7:2];
    assign lane     = bus.addr[1:0];
    assign bus.hit  = sel_hit;

    always_comb begin
        load_ok = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: load_ok = 1'b1;
            3'b001, 3'b101: load_ok = ~bus.addr[0];
            3'b010:         load_ok = (lane == 2'b00);
            default:        load_ok = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the byte mask alone picks the target bytes.
    always_comb begin
        store_ok   = 1'b0;
        byte_mask  = 4'b0000;
        store_data = bus.write_data;
        case (bus.funct3)
            3'b000: begin
                store_ok   = 1'b1;
                byte_mask  = 4'b0001 << lane;
                store_data = {4{bus.write_data[7:0]}};
            end
            3'b001: begin
                store_ok   = ~bus.addr[0];
                byte_mask  = bus.addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.write_data[15:0]}};
            end
            3'b010: begin
                store_ok   = (lane == 2'b00);
                byte_mask  = 4'b1111;
                store_data = bus.write_data;
            end
            default: begin
                store_ok   = 1'b0;
                byte_mask  = 4'b0000;
                store_data = bus.write_data;
            end
        endcase
    end

    assign bit_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};

    always_comb begin
        reg_word = 32'h0;
        case (word_idx)
            IDX_GPIO_OUT: reg_word = gpio_out;
            IDX_GPIO_IN:  reg_word = 32'(sync2);
            IDX_CTRL:     reg_word = {29'h0, ctrl};
            IDX_COUNT:    reg_word = count;
            IDX_CMP:      reg_word = cmp;
            IDX_STATUS:   reg_word = {31'h0, pending};
            default:      reg_word = 32'h0;
        endcase
    end

    assign byte_shifted = reg_word >> {lane, 3'b000};
    assign byte_sel     = byte_shifted[7:0];
    assign half_sel     = bus.addr[1] ? reg_word[31:16] : reg_word[15:0];

    always_comb begin
        load_val = 32'h0;
        case (bus.funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0, half_sel};
            3'b010:  load_val = reg_word;
            default: load_val = 32'h0;
        endcase
    end

    assign bus.read_data = (bus.mem_read && sel_hit && load_ok) ? load_val : 32'h0;

    assign wr_en     = bus.mem_write && sel_hit && store_ok;
    assign wr_gpio   = wr_en && (word_idx == IDX_GPIO_OUT);
    assign wr_ctrl   = wr_en && (word_idx == IDX_CTRL);
    assign wr_count  = wr_en && (word_idx == IDX_COUNT);
    assign wr_cmp    = wr_en && (word_idx == IDX_CMP);
    assign wr_status = wr_en && (word_idx == IDX_STATUS);

    assign ctrl_new     = (ctrl & ~bit_mask[2:0]) | (store_data[2:0] & bit_mask[2:0]);
    assign status_clear = wr_status && byte_mask[0] && store_data[0];

    // A CPU write to COUNT suppresses the compare for that tick; CMP compares pre-edge value.
    assign tick  = ctrl[0] && (presc == PRESC_MAX);
    assign match = tick && !wr_count && (count == cmp);

    assign irq = pending & ctrl[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= 32'h0;
            ctrl     <= 3'b000;
            count    <= 32'h0;
            cmp      <= 32'hFFFF_FFFF;
            pending  <= 1'b0;
            presc    <= 16'h0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;

            if (wr_gpio) begin
                gpio_out <= merge(gpio_out, store_data, bit_mask);
            end
            if (wr_ctrl) begin
                ctrl <= ctrl_new;
            end
            if (wr_cmp) begin
                cmp <= merge(cmp, store_data, bit_mask);
            end

            if (!ctrl[0] || (wr_ctrl && !ctrl_new[0]) || tick) begin
                presc <= 16'h0;
            end else begin
                presc <= presc + 16'h1;
            end

            if (wr_count) begin
                count <= merge(count, store_data, bit_mask);
            end else if (tick) begin
                if (match && ctrl[1]) begin
                    count <= 32'h0;
                end else begin
                    count <= count + 32'h1;
                end
            end

            // Setting on a match outranks a same-cycle write-1-to-clear.
            if (match) begin
                pending <= 1'b1;
            end else if (status_clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mmio_timer_gpio.md
Name: mmio_timer_gpio

Overview:
- Memory-mapped peripheral responder on the CPU data-bus port.
- Answers the same load/store transactions the core issues to data memory: addr, write_data, funct3, mem_read, mem_write, read_data.
- Provides a GPIO output register, a synchronized GPIO input register and a prescaled 32-bit timer with compare match and interrupt.
- The CPU selects between data memory and this block using hit.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte base of the 256-byte register window; must be 256-byte aligned.
- PRESCALE, 4, timer tick period in clk cycles; legal range 1..65535.
- GPIO_IN_W, 8, width of gpio_in.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  32  byte address from CPU ALU result
- write_data  in  32  store data (rs2)
- funct3  in  3  access size/sign: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- mem_read  in  1  load request
- mem_write  in  1  store request
- read_data  out  32  load result, combinational
- hit  out  1  addr inside window, combinational
- gpio_out  out  32  GPIO_OUT register
- gpio_in  in  GPIO_IN_W  asynchronous external inputs
- irq  out  1  pending & irq_en

Behaviour:
- Decode
  - hit = (addr[31:8] == BASE_ADDR[31:8]).
  - Register offset = addr[7:0].
  - Unmapped offsets read 0 and ignore writes.
- Register map
  - 0x00 GPIO_OUT, RW, reset 0.
  - 0x04 GPIO_IN, RO, zero-extended synchronized input.
  - 0x08 CTRL, RW: bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0; reset 0.
  - 0x0C COUNT, RW, reset 0.
  - 0x10 CMP, RW, reset 32'hFFFF_FFFF.
  - 0x14 STATUS: bit0 pending; write 1 clears, write 0 has no effect; reset 0.
- Reads
  - read_data is combinational in the same cycle as addr/mem_read, with zero latency (single-cycle core).
  - read_data = 0 when !mem_read or !hit.
  - Reads have no side effects.
- Sizing and alignment
  - LB/LBU select the byte at addr[1:0]; LH/LHU select the halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
  - SB/SH merge into the addressed byte/halfword of the target register; other bytes are unchanged.
  - Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0): read returns 0, write is ignored.
  - Reserved funct3 values: read 0, write ignored.
- Writes
  - Take effect at the rising clk edge when mem_write && hit && aligned.
  - If mem_read and mem_write are both high, the write is performed and read_data still reflects pre-edge contents.
- GPIO_IN synchronizer
  - Two flops, reset 0.
  - An input change becomes readable 2 clk edges later.
- Prescaler
  - Counter runs 0..PRESCALE-1 only while en=1.
  - tick is asserted in the cycle where the counter equals PRESCALE-1, then the counter wraps to 0.
  - Writing CTRL.en=0 clears the prescaler to 0; with PRESCALE=1, tick is asserted every enabled cycle.
- Timer, on tick
  - If COUNT==CMP: pending<=1; COUNT<=0 if autoreload, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF to 0 silently.
- Simultaneous events
  - CPU write to COUNT in a tick cycle: CPU value wins, and no match is evaluated that cycle.
  - STATUS W1C in the same cycle as a match-set: set wins, pending stays 1.
  - CPU write to CMP in a tick cycle: compare uses the old CMP.
- Interrupt
  - irq is registered-state based: irq = pending & CTRL.irq_en, with no extra latency beyond pending.
- Reset
  - Synchronous; it overrides any access in the same cycle.
  - All registers, prescaler and synchronizer return to their reset values, mid-count included.
  - After reset, irq=0 and gpio_out=0.

Test Plan:
- Reset then LW at 0x0001_0010 -> read_data=32'hFFFF_FFFF; hit=1; gpio_out=0; irq=0.
- SW 32'h1234_5678 to 0x0001_0000, then SB 8'hAB to 0x0001_0002 -> gpio_out=32'h12AB_5678. LB from 0x0001_0002 -> 32'hFFFF_FFAB; LBU -> 32'h0000_00AB. SW to 0x0001_0001 -> ignored, gpio_out unchanged.
- PRESCALE=4, CMP=3, CTRL=3'b111 -> COUNT increments every 4 cycles. On the 4th tick, pending=1, irq=1, COUNT=0. Further ticks continue 0,1,2,3 and re-match.
- Force a match-set in the same cycle as SW 1 to STATUS (0x14) -> pending stays 1. W1C the next cycle -> pending=0, irq=0.
- COUNT=32'hFFFF_FFFE, CMP=5, autoreload=0, en=1 -> COUNT goes FFFF_FFFF then 0 then 1, with no pending. SW 9 to COUNT in a tick cycle -> COUNT=9.
- Drive gpio_in=8'h5A -> LW 0x0001_0004 returns 0 for 2 edges, then 32'h0000_005A. Access at 0x0002_0000 -> hit=0, read_data=0, no register change. Assert rst mid-count -> all reset values on the next edge.
